ccip_c1tx_arbiter: RTL and testbench
====================================

# ccip_c1tx_arbiter

Shares the CCI-P c1Tx write channel between NUM_REQ AFU-internal write requesters. It does round-robin arbitration and holds at most one registered output beat. It limits the number of writes issued while c1TxAlmFull is high, so the channel never exceeds the 8-packet almost-full allowance. It also caps outstanding writes by tracking c1Rx write responses. It sits between the AFU engines and the c1Tx fields of the top-level CCI-P wrapper.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ALMFULL_BUDGET, 4: maximum acceptances while c1TxAlmFull is high, 1..7.
- MAX_OUTSTANDING, 64: maximum issued writes not yet acknowledged, 1..1023.
- pClk  in  1  clock; all state on rising edge.
- pck_cp2af_softReset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester write valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high; a beat is accepted when valid & ready.
- req_hdr  in  NUM_REQ*CCIP_C1TX_HDR_WIDTH  flat headers; requester i occupies slice i.
- req_data  in  NUM_REQ*CCIP_CLDATA_WIDTH  flat cache-line data; requester i occupies slice i.
- c1TxAlmFull  in  1  almost-full from the FIU.
- c1Rx_rspValid  in  1  write response; one per issued write. Only single-line writes are allowed.
- c1Tx_hdr  out  CCIP_C1TX_HDR_WIDTH  registered header.
- c1Tx_data  out  CCIP_CLDATA_WIDTH  registered data.
- c1Tx_valid  out  1  registered valid.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  count of issued writes not yet acknowledged.
- rsp_underflow  out  1  sticky flag: a response arrived while outstanding was 0.

## Operation
- Round-robin pointer ptr holds the index with highest priority.
  - The grant goes to the first requester with valid set, searching ptr, ptr+1, … with wrap-around modulo NUM_REQ.
  - After an acceptance from requester g, ptr ← (g+1) mod NUM_REQ.
  - ptr does not change when nothing is accepted.
- block is asserted when either condition holds:
  - c1TxAlmFull & (af_cnt ≥ ALMFULL_BUDGET);
  - outstanding ≥ MAX_OUTSTANDING.
- req_ready[g] = grant[g] & ~block. This is combinational from req_valid, the pointer, the counters and c1TxAlmFull.
- af_cnt (3 bits):
  - incremented on each acceptance while c1TxAlmFull = 1;
  - cleared in any cycle where c1TxAlmFull = 0, even if an acceptance occurs in that cycle.
- outstanding counter:
  - +1 on acceptance; −1 on c1Rx_rspValid; unchanged when both occur in the same cycle.
  - A response with outstanding = 0 and no acceptance in the same cycle: counter stays at 0 and rsp_underflow is set.
- There is no backpressure on c1Tx. The output register loads the accepted hdr/data every acceptance cycle. c1Tx_valid follows acceptance one cycle later.

## Timing
- Latency: accepted at cycle t → c1Tx_valid = 1 with that beat at t+1. Back-to-back acceptances give one beat per cycle.
- Almost-full limit: at most ALMFULL_BUDGET + 1 c1Tx_valid beats per almost-full episode (budget plus the one already in the register). This is at most 8.
- Reset (asynchronous assert, synchronous release is the wrapper's job):
  - c1Tx_valid = 0, c1Tx_hdr = 0, c1Tx_data = 0;
  - req_ready = 0 while reset is active;
  - ptr = 0, af_cnt = 0, outstanding = 0, rsp_underflow = 0.
- Reset mid-operation: any beat held in the register is dropped and the counters are lost. Software must re-initialise.
- Simultaneous c1TxAlmFull rising edge and acceptance: the acceptance counts toward af_cnt.

## Structure
- Package ccip_arb_pkg holds t_arb_idx (logic [2:0]) and the parameter-range check constants. Header and data widths come from ccip_if_pkg.
- One sub-module, rr_arbiter:
  - parameter N; inputs req[N], ptr, advance;
  - output one-hot grant; holds and updates ptr internally.
- The top level contains the counters, the block logic and the output register.

## Test plan
- All 4 requesters hold valid for 8 cycles, no almFull → grants 0,1,2,3,0,1,2,3. Each beat appears on c1Tx one cycle after its acceptance. outstanding reaches 8.
- c1TxAlmFull held high with req 1 always valid → exactly 4 acceptances, then req_ready stays 0. Total c1Tx_valid beats during almFull ≤ 5. Dropping almFull resumes acceptance in the same cycle.
- MAX_OUTSTANDING = 2, no responses → 2 acceptances, then stall. One c1Rx_rspValid → one more acceptance. Response coinciding with acceptance → outstanding unchanged.
- c1Rx_rspValid with outstanding = 0 → outstanding stays 0, rsp_underflow = 1 and stays set until reset.
- Assert reset while c1Tx_valid = 1 and outstanding = 5 → immediately c1Tx_valid = 0, outstanding = 0, req_ready = 0. After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/ccip_c1tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ccip_arb_pkg
//  Description : Types and legal parameter ranges for ccip_c1tx_arbiter.
//                t_arb_idx is wide enough for up to 8 requesters.
//  Revision    : 1.0  initial release
// ============================================================================
package ccip_arb_pkg;

    typedef logic [2:0] t_arb_idx;

    localparam int c_num_req_min         = 2;
    localparam int c_num_req_max         = 8;
    localparam int c_almfull_budget_min  = 1;
    localparam int c_almfull_budget_max  = 7;
    localparam int c_max_outstanding_min = 1;
    localparam int c_max_outstanding_max = 1023;

endpackage : ccip_arb_pkg
`default_nettype wire

// File: rtl/ccip_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ccip_if_pkg
//  Description : CCI-P field widths shared by the c1Tx arbiter slice.
//                Holds the c1Tx header width and the cache-line data width.
//  Revision    : 1.0  initial release
// ============================================================================
package ccip_if_pkg;

    localparam int CCIP_C1TX_HDR_WIDTH = 80;
    localparam int CCIP_CLDATA_WIDTH   = 512;

endpackage : ccip_if_pkg
`default_nettype wire

// File: rtl/ccip_c1tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ccip_c1tx_arbiter_if
//  Description : Bundle of requester-side and c1Tx/c1Rx-side signals of the
//                c1Tx arbiter.
//  Ports       : req_valid/req_ready/req_hdr/req_data  requester handshake
//                c1TxAlmFull, c1Rx_rspValid            FIU flow control
//                c1Tx_hdr/c1Tx_data/c1Tx_valid         registered c1Tx beat
//                slave modport  : the arbiter
//                master modport : requesters + FIU side
//  Revision    : 1.0  initial release
// ============================================================================
interface ccip_c1tx_arbiter_if
    import ccip_if_pkg::*;
#(
    parameter int NUM_REQ = 4
) ();

    logic [NUM_REQ-1:0]                     req_valid;
    logic [NUM_REQ-1:0]                     req_ready;
    logic [NUM_REQ*CCIP_C1TX_HDR_WIDTH-1:0] req_hdr;
    logic [NUM_REQ*CCIP_CLDATA_WIDTH-1:0]   req_data;
    logic                                   c1TxAlmFull;
    logic                                   c1Rx_rspValid;
    logic [CCIP_C1TX_HDR_WIDTH-1:0]         c1Tx_hdr;
    logic [CCIP_CLDATA_WIDTH-1:0]           c1Tx_data;
    logic                                   c1Tx_valid;

    modport slave (
        input  req_valid, req_hdr, req_data, c1TxAlmFull, c1Rx_rspValid,
        output req_ready, c1Tx_hdr, c1Tx_data, c1Tx_valid
    );

    modport master (
        output req_valid, req_hdr, req_data, c1TxAlmFull, c1Rx_rspValid,
        input  req_ready, c1Tx_hdr, c1Tx_data, c1Tx_valid
    );

endinterface : ccip_c1tx_arbiter_if
`default_nettype wire

// File: rtl/ccip_c1tx_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter with internally held priority pointer.
//                The pointer names the highest-priority requester; after an
//                acceptance from g it moves to (g+1) mod N.
//  Ports       : pClk, pck_cp2af_softReset_n  clock / async active-low reset
//                req      per-requester request
//                advance  the current grant was accepted this cycle
//                grant    one-hot grant (zero when no request)
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
    import ccip_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         pClk,
    input  logic         pck_cp2af_softReset_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    t_arb_idx r_ptr;
    t_arb_idx w_hi_idx;
    t_arb_idx w_lo_idx;
    t_arb_idx w_idx;
    logic     w_hi_found;
    logic     w_any;

    // Two candidate winners: the lowest requesting index at or above the
    // pointer (no wrap needed) and the lowest requesting index overall (the
    // wrapped winner). Scanning downwards leaves the lowest index in each.
    always_comb begin
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        w_hi_found = 1'b0;
        w_any      = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j]) begin
                w_lo_idx = t_arb_idx'(j);
                w_any    = 1'b1;
                if (t_arb_idx'(j) >= r_ptr) begin
                    w_hi_idx   = t_arb_idx'(j);
                    w_hi_found = 1'b1;
                end
            end
        end
        w_idx = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    always_comb begin
        grant = '0;
        for (int j = 0; j < N; j++) begin
            grant[j] = w_any && (w_idx == t_arb_idx'(j));
        end
    end

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (w_idx == t_arb_idx'(N - 1)) ? '0 : w_idx + 3'd1;
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/ccip_c1tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ccip_c1tx_arbiter
//  Description : Shares the CCI-P c1Tx write channel between NUM_REQ write
//                requesters. Round-robin grant, one registered output beat,
//                a bounded number of acceptances while c1TxAlmFull is high,
//                and a cap on writes awaiting their c1Rx response.
//  Ports       : pClk                   clock
//                pck_cp2af_softReset_n  async active-low reset
//                bus (slave)            requester handshake + c1Tx/c1Rx
//                outstanding            issued writes not yet acknowledged
//                rsp_underflow          sticky: response seen at count 0
//  Revision    : 1.0  initial release
// ============================================================================
module ccip_c1tx_arbiter
    import ccip_if_pkg::*;
    import ccip_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int ALMFULL_BUDGET  = 4,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic                                   pClk,
    input  logic                                   pck_cp2af_softReset_n,
    ccip_c1tx_arbiter_if.slave                     bus,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   rsp_underflow
);

    localparam int c_out_w = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_hw    = CCIP_C1TX_HDR_WIDTH;
    localparam int c_dw    = CCIP_CLDATA_WIDTH;

    if (NUM_REQ < c_num_req_min || NUM_REQ > c_num_req_max) begin : g_bad_num_req
        $error("ccip_c1tx_arbiter: NUM_REQ out of range");
    end
    if (ALMFULL_BUDGET < c_almfull_budget_min ||
        ALMFULL_BUDGET > c_almfull_budget_max) begin : g_bad_budget
        $error("ccip_c1tx_arbiter: ALMFULL_BUDGET out of range");
    end
    if (MAX_OUTSTANDING < c_max_outstanding_min ||
        MAX_OUTSTANDING > c_max_outstanding_max) begin : g_bad_max_out
        $error("ccip_c1tx_arbiter: MAX_OUTSTANDING out of range");
    end

    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_ready;
    logic               w_block;
    logic               w_accept;
    logic [c_hw-1:0]    w_sel_hdr;
    logic [c_dw-1:0]    w_sel_data;

    logic [2:0]         r_af_cnt;
    logic [c_out_w-1:0] r_outstanding;
    logic               r_underflow;
    logic [c_hw-1:0]    r_c1tx_hdr;
    logic [c_dw-1:0]    r_c1tx_data;
    logic               r_c1tx_valid;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .pClk                  (pClk),
        .pck_cp2af_softReset_n (pck_cp2af_softReset_n),
        .req                   (bus.req_valid),
        .advance               (w_accept),
        .grant                 (w_grant)
    );

    // The af_cnt term only applies while almost-full is high, so dropping
    // c1TxAlmFull re-opens acceptance in that same cycle.
    assign w_block = (bus.c1TxAlmFull && (r_af_cnt >= 3'(ALMFULL_BUDGET))) ||
                     (r_outstanding >= c_out_w'(MAX_OUTSTANDING));

    // Ready is held low during reset so no requester sees a spurious accept.
    assign w_ready  = w_grant & {NUM_REQ{~w_block & pck_cp2af_softReset_n}};
    assign w_accept = |w_ready;

    always_comb begin
        w_sel_hdr  = '0;
        w_sel_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_grant[j]) begin
                w_sel_hdr  = bus.req_hdr[j*c_hw +: c_hw];
                w_sel_data = bus.req_data[j*c_dw +: c_dw];
            end
        end
    end

    // Almost-full episode counter: cleared whenever almost-full is low,
    // including a cycle that also accepts.
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            r_af_cnt <= '0;
        end else if (!bus.c1TxAlmFull) begin
            r_af_cnt <= '0;
        end else if (w_accept) begin
            r_af_cnt <= r_af_cnt + 3'd1;
        end
    end

    // Outstanding writes. Accept and response in one cycle cancel out.
    // The count cannot exceed MAX_OUTSTANDING because w_block stops
    // acceptance there.
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            r_outstanding <= '0;
            r_underflow   <= 1'b0;
        end else if (w_accept && !bus.c1Rx_rspValid) begin
            r_outstanding <= r_outstanding + c_out_w'(1);
        end else if (!w_accept && bus.c1Rx_rspValid) begin
            if (r_outstanding == '0) begin
                r_underflow <= 1'b1;
            end else begin
                r_outstanding <= r_outstanding - c_out_w'(1);
            end
        end
    end

    // Single output register; c1Tx has no backpressure.
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            r_c1tx_valid <= 1'b0;
            r_c1tx_hdr   <= '0;
            r_c1tx_data  <= '0;
        end else begin
            r_c1tx_valid <= w_accept;
            if (w_accept) begin
                r_c1tx_hdr  <= w_sel_hdr;
                r_c1tx_data <= w_sel_data;
            end
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.c1Tx_valid = r_c1tx_valid;
    assign bus.c1Tx_hdr   = r_c1tx_hdr;
    assign bus.c1Tx_data  = r_c1tx_data;
    assign outstanding    = r_outstanding;
    assign rsp_underflow  = r_underflow;

endmodule : ccip_c1tx_arbiter
`default_nettype wire

// File: tb/tb_ccip_c1tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ccip_c1tx_arbiter
//  Description : Directed self-checking bench. Instance A uses the default
//                parameters; instance B uses MAX_OUTSTANDING = 2.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ccip_c1tx_arbiter;
    import ccip_if_pkg::*;

    localparam int c_hw = CCIP_C1TX_HDR_WIDTH;
    localparam int c_dw = CCIP_CLDATA_WIDTH;

    logic       pClk = 1'b0;
    logic       rst_n;
    logic [6:0] out_a;
    logic [1:0] out_b;
    logic       uf_a;
    logic       uf_b;
    int         errors = 0;
    int         checks = 0;
    int         acc;
    int         beats;

    always #5 pClk = ~pClk;

    ccip_c1tx_arbiter_if #(.NUM_REQ(4)) bus_a ();
    ccip_c1tx_arbiter_if #(.NUM_REQ(4)) bus_b ();

    ccip_c1tx_arbiter #(
        .NUM_REQ(4), .ALMFULL_BUDGET(4), .MAX_OUTSTANDING(64)
    ) dut_a (
        .pClk(pClk), .pck_cp2af_softReset_n(rst_n), .bus(bus_a),
        .outstanding(out_a), .rsp_underflow(uf_a)
    );

    ccip_c1tx_arbiter #(
        .NUM_REQ(4), .ALMFULL_BUDGET(4), .MAX_OUTSTANDING(2)
    ) dut_b (
        .pClk(pClk), .pck_cp2af_softReset_n(rst_n), .bus(bus_b),
        .outstanding(out_b), .rsp_underflow(uf_b)
    );

    function automatic logic [c_hw-1:0] exp_hdr(input int i);
        logic [3:0] k;
        k = 4'(i);
        return {16'hC0DE, 60'h0, k};
    endfunction

    function automatic logic [c_dw-1:0] exp_data(input int i);
        logic [7:0] k;
        k = 8'hA0 | 8'(i);
        return {k, 496'h0, k};
    endfunction

    task automatic check(input string tag, input logic [c_dw-1:0] obs,
                         input logic [c_dw-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus_a.c1TxAlmFull = 1'b0; bus_a.c1Rx_rspValid = 1'b0;
        bus_b.c1TxAlmFull = 1'b0; bus_b.c1Rx_rspValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_a.req_hdr[i*c_hw +: c_hw]  = exp_hdr(i);
            bus_a.req_data[i*c_dw +: c_dw] = exp_data(i);
            bus_b.req_hdr[i*c_hw +: c_hw]  = exp_hdr(i);
            bus_b.req_data[i*c_dw +: c_dw] = exp_data(i);
        end
        bus_a.req_valid = 4'hF;
        bus_b.req_valid = 4'hF;
        #2;
        // Reset state
        check("rst_ready_a", bus_a.req_ready, 0);
        check("rst_ready_b", bus_b.req_ready, 0);
        check("rst_valid_a", bus_a.c1Tx_valid, 0);
        check("rst_hdr_a", bus_a.c1Tx_hdr, 0);
        check("rst_data_a", bus_a.c1Tx_data, 0);
        check("rst_out_a", out_a, 0);
        check("rst_uf_a", uf_a, 0);
        bus_b.req_valid = 4'h0;
        @(negedge pClk);
        rst_n = 1'b1;

        // Round robin, all four requesters valid for 8 cycles
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("rr_ready_%0d", k), bus_a.req_ready, 4'b0001 << (k % 4));
            @(posedge pClk); #1;
            check($sformatf("rr_valid_%0d", k), bus_a.c1Tx_valid, 1);
            check($sformatf("rr_hdr_%0d", k), bus_a.c1Tx_hdr, exp_hdr(k % 4));
            check($sformatf("rr_data_%0d", k), bus_a.c1Tx_data, exp_data(k % 4));
            if (k == 7) bus_a.req_valid = 4'h0;
            @(negedge pClk);
        end
        check("rr_out8", out_a, 8);
        @(posedge pClk); #1;
        check("rr_idle_valid", bus_a.c1Tx_valid, 0);

        // Almost-full budget with requester 1 always valid
        @(negedge pClk);
        bus_a.c1TxAlmFull = 1'b1;
        bus_a.req_valid   = 4'b0010;
        acc = 0;
        beats = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (bus_a.req_ready[1]) acc++;
            @(posedge pClk); #1;
            if (bus_a.c1Tx_valid) beats++;
            @(negedge pClk);
        end
        #1;
        check("af_blocked_ready", bus_a.req_ready, 0);
        check("af_accepts", acc, 4);
        check("af_beats", beats, 4);
        check("af_beats_le5", (beats <= 5), 1);
        bus_a.c1TxAlmFull = 1'b0;
        #1;
        check("af_drop_ready", bus_a.req_ready, 4'b0010);
        @(posedge pClk); #1;
        check("af_drop_valid", bus_a.c1Tx_valid, 1);
        check("af_out13", out_a, 13);
        bus_a.req_valid = 4'h0;

        // Instance B: underflow then outstanding cap of 2
        @(negedge pClk);
        bus_b.c1Rx_rspValid = 1'b1;
        @(posedge pClk); #1;
        check("uf_out0", out_b, 0);
        check("uf_flag", uf_b, 1);
        bus_b.c1Rx_rspValid = 1'b0;
        @(negedge pClk);
        bus_b.req_valid = 4'b0001;
        #1;
        check("cap_ready1", bus_b.req_ready, 4'b0001);
        @(posedge pClk); #1;
        check("cap_out1", out_b, 1);
        check("cap_hdr", bus_b.c1Tx_hdr, exp_hdr(0));
        @(negedge pClk); #1;
        check("cap_ready2", bus_b.req_ready, 4'b0001);
        @(posedge pClk); #1;
        check("cap_out2", out_b, 2);
        @(negedge pClk); #1;
        check("cap_stall_ready", bus_b.req_ready, 0);
        @(posedge pClk); #1;
        check("cap_stall_out", out_b, 2);
        check("cap_stall_valid", bus_b.c1Tx_valid, 0);
        @(negedge pClk);
        bus_b.c1Rx_rspValid = 1'b1;
        #1;
        check("cap_rsp_ready", bus_b.req_ready, 0);
        @(posedge pClk); #1;
        check("cap_rsp_out", out_b, 1);
        @(negedge pClk);
        bus_b.c1Rx_rspValid = 1'b0;
        #1;
        check("cap_resume_ready", bus_b.req_ready, 4'b0001);
        @(posedge pClk); #1;
        check("cap_resume_out", out_b, 2);
        @(negedge pClk); #1;
        check("cap_stall2_ready", bus_b.req_ready, 0);
        bus_b.req_valid = 4'h0;
        bus_b.c1Rx_rspValid = 1'b1;
        @(posedge pClk); #1;
        check("cap_rsp2_out", out_b, 1);
        @(negedge pClk);
        bus_b.req_valid = 4'b0001;
        #1;
        check("coin_b_ready", bus_b.req_ready, 4'b0001);
        @(posedge pClk); #1;
        check("coin_b_out", out_b, 1);
        check("uf_sticky", uf_b, 1);
        bus_b.req_valid = 4'h0;
        bus_b.c1Rx_rspValid = 1'b0;

        // Instance A: drain 8 responses (13 -> 5)
        @(negedge pClk);
        bus_a.c1Rx_rspValid = 1'b1;
        repeat (8) @(posedge pClk);
        #1;
        bus_a.c1Rx_rspValid = 1'b0;
        check("drain_out5", out_a, 5);

        // Accept from requester 2 with a coincident response
        @(negedge pClk);
        bus_a.req_valid = 4'b0100;
        bus_a.c1Rx_rspValid = 1'b1;
        #1;
        check("coin_a_ready", bus_a.req_ready, 4'b0100);
        @(posedge pClk); #1;
        check("coin_a_out", out_a, 5);
        check("coin_a_valid", bus_a.c1Tx_valid, 1);
        check("coin_a_hdr", bus_a.c1Tx_hdr, exp_hdr(2));

        // Asynchronous reset with a beat in the register
        bus_a.c1Rx_rspValid = 1'b0;
        bus_a.req_valid = 4'hF;
        rst_n = 1'b0;
        #1;
        check("mrst_valid", bus_a.c1Tx_valid, 0);
        check("mrst_out", out_a, 0);
        check("mrst_ready", bus_a.req_ready, 0);
        check("mrst_hdr", bus_a.c1Tx_hdr, 0);
        check("mrst_uf_b", uf_b, 0);
        @(negedge pClk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", bus_a.req_ready, 4'b0001);
        @(posedge pClk); #1;
        check("post_rst_hdr", bus_a.c1Tx_hdr, exp_hdr(0));
        check("post_rst_out", out_a, 1);
        bus_a.req_valid = 4'h0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ccip_c1tx_arbiter
`default_nettype wire
